// File: rtl/sigma_sched_4ch.sv
`default_nettype none
// ============================================================================
// sigma_sched_4ch : 4-channel round-robin scheduler with a shared 16-sample
//                   sign-magnitude accumulator and per-frame stall timeout.
// Revision 1.0
// ============================================================================
module sigma_sched_4ch #(
  parameter int SAMPLES = 16,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        res,
  input  logic [3:0]  req,
  input  logic [3:0]  smp_vld,
  input  logic [31:0] data_in,
  output logic [3:0]  gnt,
  output logic [3:0]  smp_ack,
  output logic [11:0] data_out,
  output logic [1:0]  ch_out,
  output logic        syn_out,
  output logic        err,
  output logic [1:0]  err_ch,
  output logic        busy
);

  localparam int              TW       = $clog2(TIMEOUT);
  localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [3:0]      CNT_LAST = 4'(SAMPLES - 1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  state_t          r_state;
  logic [1:0]      r_ptr;
  logic [1:0]      r_id;
  logic [3:0]      r_cnt;
  logic [11:0]     r_sum;
  logic [TW-1:0]   r_to;
  logic [3:0]      r_gnt;
  logic [11:0]     r_dout;
  logic [1:0]      r_ch;
  logic            r_syn;
  logic            r_err;
  logic [1:0]      r_errch;
  logic            r_busy;

  logic [1:0]      w_sel;
  logic [1:0]      w_idx;
  logic            w_found;
  logic [7:0]      w_byte;
  logic [11:0]     w_mag;
  logic [11:0]     w_smp;
  logic [11:0]     w_sum_nx;
  logic            w_acc;

  // Scan from the farthest offset down so the nearest requester at/after r_ptr wins.
  always_comb begin
    w_sel = r_ptr;
    w_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_ptr + 2'(k);
      if (req[w_idx]) w_sel = w_idx;
    end
  end

  assign w_found  = |req;
  assign w_byte   = data_in[{r_id, 3'b000} +: 8];
  assign w_mag    = {5'b00000, w_byte[6:0]};
  // Negative zero negates to zero, so no special case is needed.
  assign w_smp    = w_byte[7] ? (12'd0 - w_mag) : w_mag;
  assign w_sum_nx = r_sum + w_smp;
  assign w_acc    = |(r_gnt & smp_vld);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_state <= S_IDLE;
      r_ptr   <= 2'd0;
      r_id    <= 2'd0;
      r_cnt   <= 4'd0;
      r_sum   <= 12'd0;
      r_to    <= '0;
      r_gnt   <= 4'd0;
      r_dout  <= 12'd0;
      r_ch    <= 2'd0;
      r_syn   <= 1'b0;
      r_err   <= 1'b0;
      r_errch <= 2'd0;
      r_busy  <= 1'b0;
    end else begin
      r_syn <= 1'b0;
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt   <= 4'b0001 << w_sel;
            r_id    <= w_sel;
            r_busy  <= 1'b1;
            r_cnt   <= 4'd0;
            r_sum   <= 12'd0;
            r_to    <= '0;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (w_acc) begin
            r_to <= '0;
            if (r_cnt == CNT_LAST) begin
              r_dout  <= w_sum_nx;
              r_ch    <= r_id;
              r_syn   <= 1'b1;
              r_gnt   <= 4'd0;
              r_busy  <= 1'b0;
              r_ptr   <= r_id + 2'd1;
              r_state <= S_IDLE;
            end else begin
              r_sum <= w_sum_nx;
              r_cnt <= r_cnt + 4'd1;
            end
          end else if (r_to == TO_LAST) begin
            r_err   <= 1'b1;
            r_errch <= r_id;
            r_gnt   <= 4'd0;
            r_busy  <= 1'b0;
            r_ptr   <= r_id + 2'd1;
            r_state <= S_IDLE;
          end else begin
            r_to <= r_to + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign smp_ack  = r_gnt & smp_vld;
  assign data_out = r_dout;
  assign ch_out   = r_ch;
  assign syn_out  = r_syn;
  assign err      = r_err;
  assign err_ch   = r_errch;
  assign busy     = r_busy;

endmodule
`default_nettype wire

// File: doc/sigma_sched_4ch.md
Name: sigma_sched_4ch

Overview:
Four-channel scheduler and shared 16-sample accumulator for sign-magnitude sample streams. Up to four requesters compete for one accumulator. A round-robin arbiter grants one channel for a full 16-sample frame, accumulates its samples and emits a 12-bit two's-complement sum tagged with the channel id. A per-frame timeout keeps a stalled channel from holding the accumulator.

Parameters:
SAMPLES, 16, samples per frame (fixed at 16 for this revision; sum width sized for it)
TIMEOUT, 64, consecutive granted cycles without a sample before the frame is aborted (>=2)

Ports:
clk  input  1  system clock, rising edge
res  input  1  asynchronous active-low reset
req  input  4  per-channel frame request, level
smp_vld  input  4  per-channel sample-valid strobe
data_in  input  32  channel i sample at [8i+7:8i], 8-bit sign-magnitude (bit7 = sign)
gnt  output  4  one-hot grant, registered
smp_ack  output  4  sample accepted this cycle, combinational = gnt & smp_vld
data_out  output  12  frame sum, two's complement, held until next frame
ch_out  output  2  channel id of data_out
syn_out  output  1  one-cycle pulse: data_out/ch_out updated
err  output  1  one-cycle pulse: frame aborted by timeout
err_ch  output  2  channel id of aborted frame
busy  output  1  high while in ACCUM

Behaviour:
- Clock is clk; reset is asynchronous and active-low on res. Reset values: gnt=0, data_out=0, ch_out=0, syn_out=0, err=0, err_ch=0, busy=0, state=IDLE, rr pointer=0, sample count=0, sum=0, timeout count=0.
- Sample conversion: bit7=0 -> +data[6:0]; bit7=1 -> -data[6:0]. 0x80 (negative zero) -> 0. Result is sign-extended to 12 bits. Range per frame is -2032..+2032, so there is no overflow.
- States: IDLE, ACCUM.
- IDLE:
  - If req!=0, select the first requesting channel at or after the rr pointer, wrapping 3->0.
  - At the next edge: gnt[sel]=1, busy=1, count=0, sum=0, timeout=0, state=ACCUM.
  - If req==0, stay in IDLE.
- ACCUM:
  - A sample is accepted in a cycle when gnt[i]&smp_vld[i].
  - smp_ack[i] is high in that same cycle.
  - smp_vld on non-granted channels is ignored; their smp_ack stays 0.
  - Each accepted sample: sum += converted sample, count += 1, timeout=0. A cycle with no accepted sample: timeout += 1.
  - On acceptance of the 16th sample (count==15), at that edge:
    - data_out <= sum + sample; ch_out <= id; syn_out <= 1.
    - gnt <= 0; busy <= 0; rr pointer <= id+1 mod 4; state <= IDLE.
  - If timeout reaches TIMEOUT-1 with no acceptance in the current cycle, at that edge:
    - err <= 1; err_ch <= id.
    - gnt <= 0; busy <= 0; rr pointer <= id+1; state <= IDLE.
    - data_out, ch_out and syn_out are unchanged.
  - Deassertion of req for the granted channel during ACCUM is ignored; the frame runs to completion or timeout.
- Timing:
  - Grant appears 1 cycle after req is sampled in IDLE.
  - syn_out rises on the edge after the 16th accepted sample.
  - There is a minimum of 1 IDLE cycle between frames; gnt is low for at least one cycle.
  - Back-to-back samples every cycle are supported, giving a minimum frame of 16 cycles.
- syn_out and err are single-cycle pulses and are never high simultaneously.
- Reset asserted mid-frame:
  - The frame is discarded immediately and all reset values apply.
  - The next frame after reset starts from sum 0 and grants from channel 0 first.

Test Plan:
1. Only req[0]=1; 16 samples of 0x01 with smp_vld every cycle -> smp_ack[0] on each; syn_out one cycle; data_out=0x010, ch_out=0; gnt=0 the same cycle syn_out is high.
2. req=4'b1111 held, every channel streaming; ch2 samples=0x85 -> grant order 0,1,2,3,0; ch2 frame gives data_out=0xFB0 (-80), ch_out=2; each gnt one-hot with an IDLE gap between frames.
3. Extremes on ch3: 16x0x7F -> data_out=0x7F0; 16x0xFF -> 0x810; 16x0x80 -> 0x000; alternating 0x7F/0xFF -> 0x000.
4. ch1 granted, 5 samples then smp_vld[1]=0 with TIMEOUT=64 -> err pulse with err_ch=1 after 64 idle granted cycles; no syn_out; data_out keeps its previous value; a pending req[2] is granted next.
5. ch0 granted, 8 samples accepted, then res low for 2 cycles -> all outputs 0 during reset; after release, a 16x0x02 frame gives data_out=0x020, confirming the partial sum was discarded.
6. ch0 granted; smp_vld[1]/[3] pulsed with 0x7F during the frame -> smp_ack[1]/[3] stay 0; ch0 result is unaffected.
